// File: rtl/picnic_ctrl_pkg.sv
// Shared control package for the Picnic/SM4 board controller: phase state
// encoding and RAM geometry shared by the sequencer, its mux and benches.
package picnic_ctrl_pkg;

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_LOAD = 3'd1,
    PH_GAP1 = 3'd2,
    PH_RUN  = 3'd3,
    PH_GAP2 = 3'd4,
    PH_DUMP = 3'd5,
    PH_DONE = 3'd6,
    PH_ERR  = 3'd7
  } ph_state_t;

  localparam int RAM_ADDR_W = 15;
  localparam int RAM_DATA_W = 8;

  // Size of the parameter image the UART loader streams in.
  localparam logic [14:0] LOAD_BYTES = 15'h22a0;

endpackage

// File: rtl/ram_port_mux.sv
// Combinational 3-master select onto the single RAM port, keyed on the
// sequencer's registered phase state.
module ram_port_mux
  import picnic_ctrl_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  ph_state_t          state,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [DATA_W-1:0]  load_din,
  input  logic               load_wea,
  input  logic [ADDR_W-1:0]  core_addr,
  input  logic [DATA_W-1:0]  core_din,
  input  logic               core_wea,
  input  logic [ADDR_W-1:0]  dump_addr,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_din,
  output logic               ram_wea
);

  // Idle/gap/terminal states park the port at zero so stray writes never land.
  always_comb begin
    ram_addr = '0;
    ram_din  = '0;
    ram_wea  = 1'b0;
    case (state)
      PH_LOAD: begin
        ram_addr = load_addr;
        ram_din  = load_din;
        ram_wea  = load_wea;
      end
      PH_RUN: begin
        ram_addr = core_addr;
        ram_din  = core_din;
        ram_wea  = core_wea;
      end
      PH_DUMP: begin
        ram_addr = dump_addr;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_phase_sequencer.sv
// Phase controller: LOAD -> RUN -> DUMP over one shared RAM port.
// Optional per-phase watchdog enabled by defining RAM_PHASE_TIMEOUT_EN.
module ram_phase_sequencer
  import picnic_ctrl_pkg::*;
#(
  parameter int          ADDR_W      = RAM_ADDR_W,
  parameter int          DATA_W      = RAM_DATA_W,
  parameter logic [31:0] TIMEOUT_CYC = 32'd50_000_000
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               go,
  output logic               load_start,
  input  logic               load_end,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [DATA_W-1:0]  load_din,
  input  logic               load_wea,
  output logic               core_start,
  input  logic               core_done,
  input  logic [ADDR_W-1:0]  core_addr,
  input  logic [DATA_W-1:0]  core_din,
  input  logic               core_wea,
  output logic               dump_start,
  input  logic               dump_end,
  input  logic [ADDR_W-1:0]  dump_addr,
  output logic [ADDR_W-1:0]  ram_addr,
  output logic [DATA_W-1:0]  ram_din,
  output logic               ram_wea,
  input  logic [DATA_W-1:0]  ram_dout,
  output logic [DATA_W-1:0]  rd_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [2:0]         state_dbg
);

  // Handshake: each *_start is a level held for the whole phase; the master
  // answers with a level/pulse on its end input, which only counts while the
  // owning phase is active (ends seen in any other state are ignored).
  ph_state_t state_q, state_nxt;

`ifdef RAM_PHASE_TIMEOUT_EN
  logic [31:0] cyc_cnt_q;
  logic        counting;
  logic        timeout_hit;

  assign counting    = (state_q == PH_LOAD) || (state_q == PH_RUN) || (state_q == PH_DUMP);
  assign timeout_hit = counting && (cyc_cnt_q == TIMEOUT_CYC - 32'd1);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)              cyc_cnt_q <= '0;
    else if (state_nxt != state_q) cyc_cnt_q <= '0;
    else if (counting)           cyc_cnt_q <= cyc_cnt_q + 32'd1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
`endif

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      PH_IDLE, PH_DONE, PH_ERR: if (go) state_nxt = PH_LOAD;
      PH_LOAD: if (load_end)  state_nxt = PH_GAP1;
      PH_GAP1:                state_nxt = PH_RUN;
      PH_RUN:  if (core_done) state_nxt = PH_GAP2;
      PH_GAP2:                state_nxt = PH_DUMP;
      PH_DUMP: if (dump_end)  state_nxt = PH_DONE;
      default:                state_nxt = PH_IDLE;
    endcase
`ifdef RAM_PHASE_TIMEOUT_EN
    // A phase end arriving on the last allowed cycle still wins.
    if (timeout_hit && (state_nxt == state_q)) state_nxt = PH_ERR;
`endif
  end

  // Starts are flopped from the next state so they track the state register exactly.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q    <= PH_IDLE;
      load_start <= 1'b0;
      core_start <= 1'b0;
      dump_start <= 1'b0;
    end else begin
      state_q    <= state_nxt;
      load_start <= (state_nxt == PH_LOAD);
      core_start <= (state_nxt == PH_RUN);
      dump_start <= (state_nxt == PH_DUMP);
    end
  end

  assign busy      = (state_q == PH_LOAD) || (state_q == PH_GAP1) || (state_q == PH_RUN) ||
                     (state_q == PH_GAP2) || (state_q == PH_DUMP);
  assign done      = (state_q == PH_DONE);
`ifdef RAM_PHASE_TIMEOUT_EN
  assign err       = (state_q == PH_ERR);
`else
  assign err       = 1'b0;
`endif
  assign rd_data   = ram_dout;
  assign state_dbg = state_q;

  ram_port_mux #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mux (
    .state     (state_q),
    .load_addr (load_addr),
    .load_din  (load_din),
    .load_wea  (load_wea),
    .core_addr (core_addr),
    .core_din  (core_din),
    .core_wea  (core_wea),
    .dump_addr (dump_addr),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_wea   (ram_wea)
  );

endmodule

// File: tb/tb_ram_phase_sequencer.sv
// Scoreboard bench for ram_phase_sequencer: start/done/err rise events and
// signal probes are queued by the driver and checked by a negedge monitor.
module tb_ram_phase_sequencer;
  import picnic_ctrl_pkg::*;

  localparam int AW = RAM_ADDR_W;
  localparam int DW = RAM_DATA_W;
`ifdef RAM_PHASE_TIMEOUT_EN
  localparam int LOAD_N = 90;
`else
  localparam int LOAD_N = int'(LOAD_BYTES);
`endif

  // Event codes for rising edges of the observed status/start outputs.
  localparam logic [3:0] EV_LOAD = 4'd0, EV_CORE = 4'd1, EV_DUMP = 4'd2,
                         EV_DONE = 4'd3, EV_ERR  = 4'd4;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] exp;
  } probe_t;

  logic sys_clk, sys_rst_n, go;
  logic load_start, load_end, load_wea;
  logic core_start, core_done, core_wea;
  logic dump_start, dump_end;
  logic [AW-1:0] load_addr, core_addr, dump_addr, ram_addr;
  logic [DW-1:0] load_din, core_din, ram_din, ram_dout, rd_data;
  logic ram_wea, busy, done, err;
  logic [2:0] state_dbg;

  logic [35:0] exp_q[$];
  probe_t      probe_q[$];
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        end_req = 1'b0;
  logic [4:0]  prev_ev = '0;
  logic [DW-1:0] mem [0:(1<<AW)-1];

  ram_phase_sequencer #(
    .ADDR_W (AW), .DATA_W (DW), .TIMEOUT_CYC (32'd100)
  ) dut (
    .sys_clk, .sys_rst_n, .go,
    .load_start, .load_end, .load_addr, .load_din, .load_wea,
    .core_start, .core_done, .core_addr, .core_din, .core_wea,
    .dump_start, .dump_end, .dump_addr,
    .ram_addr, .ram_din, .ram_wea, .ram_dout, .rd_data,
    .busy, .done, .err, .state_dbg
  );

  // ---------------- clock / reset, RAM macro model ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) begin
    cyc <= cyc + 1;
    if (cyc == 0) begin
      for (int i = 0; i < (1 << AW); i++) mem[i] <= '0;
    end else if (ram_wea) begin
      mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout = mem[ram_addr];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [DW-1:0] pat(input int a);
    pat = DW'(a * 7 + 3);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge sys_clk);
      #2;
    end
  endtask

  task automatic probe(input logic [3:0] id, input logic [31:0] exp);
    probe_t p;
    p.id = id;
    p.exp = exp;
    probe_q.push_back(p);
  endtask

  task automatic expect_ev(input logic [3:0] code, input int unsigned at);
    exp_q.push_back({code, at});
  endtask

  task automatic pulse_go(input logic expect_load);
    go = 1'b1;
    if (expect_load) expect_ev(EV_LOAD, cyc + 1);
    step();
    go = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  function automatic string probe_name(input logic [3:0] id);
    case (id)
      4'd0: probe_name = "state";
      4'd1: probe_name = "busy";
      4'd2: probe_name = "done";
      4'd3: probe_name = "err";
      4'd4: probe_name = "load_start";
      4'd5: probe_name = "core_start";
      4'd6: probe_name = "dump_start";
      4'd7: probe_name = "ram_addr";
      4'd8: probe_name = "ram_wea";
      4'd9: probe_name = "ram_din";
      default: probe_name = "rd_data";
    endcase
  endfunction

  function automatic logic [31:0] probe_val(input logic [3:0] id);
    case (id)
      4'd0: probe_val = 32'(state_dbg);
      4'd1: probe_val = 32'(busy);
      4'd2: probe_val = 32'(done);
      4'd3: probe_val = 32'(err);
      4'd4: probe_val = 32'(load_start);
      4'd5: probe_val = 32'(core_start);
      4'd6: probe_val = 32'(dump_start);
      4'd7: probe_val = 32'(ram_addr);
      4'd8: probe_val = 32'(ram_wea);
      4'd9: probe_val = 32'(ram_din);
      default: probe_val = 32'(rd_data);
    endcase
  endfunction

  always @(negedge sys_clk) begin
    logic [4:0]  cur_ev;
    logic [35:0] e;
    probe_t      p;
    logic [31:0] act;
    while (probe_q.size() > 0) begin
      p = probe_q.pop_front();
      act = probe_val(p.id);
      n_checks++;
      if (act !== p.exp) begin
        n_fail++;
        $display("FAIL %s at cyc %0d: got %0h expected %0h", probe_name(p.id), cyc, act, p.exp);
      end
    end
    cur_ev = {err, done, dump_start, core_start, load_start};
    if (sys_rst_n) begin
      for (int k = 0; k < 5; k++) begin
        if (cur_ev[k] && !prev_ev[k]) begin
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: unexpected rise code %0d at cyc %0d, none expected", k, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e !== {4'(k), cyc}) begin
              n_fail++;
              $display("FAIL event: got code %0d cyc %0d expected code %0d cyc %0d",
                       k, cyc, e[35:32], e[31:0]);
            end
          end
        end
      end
    end
    prev_ev = cur_ev;
    if (end_req) begin
      n_checks++;
      if (exp_q.size() != 0) begin
        n_fail++;
        $display("FAIL drain: %0d expected events never seen, expected 0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    logic [AW-1:0] rd_list [6];
    int unsigned c;
    sys_rst_n = 1'b0; go = 1'b0;
    load_end = 1'b0; load_addr = '0; load_din = '0; load_wea = 1'b0;
    core_done = 1'b0; core_addr = '0; core_din = '0; core_wea = 1'b0;
    dump_end = 1'b0; dump_addr = '0;
    #2;
    probe(0, PH_IDLE); probe(1, 0); probe(2, 0); probe(3, 0);
    probe(4, 0); probe(5, 0); probe(6, 0); probe(7, 0); probe(8, 0); probe(9, 0);
    step(3);
    sys_rst_n = 1'b1;
    step(2);

    // Run 1: full load, core write, dump readback.
    pulse_go(1'b1);
    probe(0, PH_LOAD); probe(1, 1); probe(4, 1);
    core_wea = 1'b1; core_addr = AW'(16'h0010); core_din = 8'hEE;
    for (int i = 0; i < LOAD_N; i++) begin
      load_addr = AW'(i); load_din = pat(i); load_wea = 1'b1;
      if (i == 16) begin
        probe(7, 32'h10); probe(8, 1); probe(9, 32'(pat(16)));
      end
      step();
    end
    load_wea = 1'b0; core_wea = 1'b0;
    load_end = 1'b1;
    expect_ev(EV_CORE, cyc + 2);
    step();
    probe(0, PH_GAP1); probe(4, 0); probe(5, 0); probe(1, 1);
    step();
    load_end = 1'b0;
    probe(0, PH_RUN);
    core_addr = AW'(5); core_din = 8'hA5; core_wea = 1'b1;
    load_addr = AW'(6); load_din = 8'h77; load_wea = 1'b1;
    probe(7, 5); probe(9, 32'hA5); probe(8, 1);
    step();
    core_wea = 1'b0;
    probe(8, 0);
    step();
    pulse_go(1'b0);
    load_wea = 1'b0;
    probe(0, PH_RUN); probe(4, 0);
    core_done = 1'b1;
    expect_ev(EV_DUMP, cyc + 2);
    step();
    core_done = 1'b0;
    step();
    probe(0, PH_DUMP); probe(6, 1);
    rd_list[0] = AW'(0);
    rd_list[1] = AW'(5);
    rd_list[2] = AW'(6);
    rd_list[3] = AW'(16);
    rd_list[4] = AW'(LOAD_N - 1);
    rd_list[5] = AW'(LOAD_N);
    for (int i = 0; i < 6; i++) begin
      dump_addr = rd_list[i];
      probe(7, 32'(rd_list[i])); probe(8, 0); probe(9, 0);
      if (rd_list[i] == AW'(5))            probe(10, 32'hA5);
      else if (int'(rd_list[i]) < LOAD_N)  probe(10, 32'(pat(int'(rd_list[i]))));
      else                                 probe(10, 0);
      step();
    end
    dump_end = 1'b1;
    expect_ev(EV_DONE, cyc + 1);
    step();
    dump_end = 1'b0;
    probe(0, PH_DONE); probe(2, 1); probe(1, 0); probe(6, 0); probe(7, 0);
    step(3);
    probe(2, 1);

    // Run 2: restart from DONE, then reset in the middle of DUMP.
    pulse_go(1'b1);
    probe(2, 0); probe(4, 1); probe(1, 1);
    load_end = 1'b1;
    expect_ev(EV_CORE, cyc + 2);
    step(2);
    load_end = 1'b0;
    core_done = 1'b1;
    expect_ev(EV_DUMP, cyc + 2);
    step();
    core_done = 1'b0;
    step(2);
    probe(6, 1);
    step();
    sys_rst_n = 1'b0;
    probe(6, 0); probe(1, 0); probe(0, PH_IDLE);
    step(2);
    sys_rst_n = 1'b1;
    step(2);

`ifdef RAM_PHASE_TIMEOUT_EN
    // Run 3: core never finishes, watchdog fires 100 cycles into RUN.
    pulse_go(1'b1);
    load_end = 1'b1;
    c = cyc;
    expect_ev(EV_CORE, c + 2);
    expect_ev(EV_ERR, c + 102);
    step(2);
    load_end = 1'b0;
    step(99);
    probe(3, 0); probe(0, PH_RUN);
    step();
    probe(3, 1); probe(5, 0); probe(1, 0); probe(0, PH_ERR);
    step(3);
    pulse_go(1'b1);
    probe(3, 0); probe(0, PH_LOAD); probe(4, 1);
`else
    c = cyc;
    probe(3, 0);
`endif
    step(5);
    end_req = 1'b1;
  end

endmodule
